// File: rtl/gpmc_sdram_bridge.sv
`default_nettype none
// ============================================================================
// gpmc_sdram_bridge : GPMC register window onto sdram_controller (bursts, FIFO)
// Optional macro GPMC_BRIDGE_STATS_EN adds WR_COUNT/RD_COUNT at regs 6/7.
// Revision: 1.0
// ============================================================================
module gpmc_sdram_bridge #(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 16,
   parameter int SD_DATA_WIDTH = 8,
   parameter int SD_ADDR_WIDTH = 25,
   parameter int RD_FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     csn,
   input  logic                     wen,
   input  logic                     oen,
   input  logic [ADDR_WIDTH-1:0]    address,
   input  logic [DATA_WIDTH-1:0]    data_out,
   output logic [DATA_WIDTH-1:0]    data_in,
   output logic [SD_ADDR_WIDTH-1:0] sd_addr,
   output logic [SD_DATA_WIDTH-1:0] sd_wr_data,
   output logic                     sd_wr_enable,
   output logic                     sd_rd_enable,
   input  logic [SD_DATA_WIDTH-1:0] sd_rd_data,
   input  logic                     sd_rd_ready,
   input  logic                     sd_busy,
   input  logic                     sd_ack,
   output logic                     sd_rst
);

   localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_LO   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_HI   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_WR   = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] A_RD   = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] A_LEN  = ADDR_WIDTH'(5);

   typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_STALL} state_t;
   state_t state, state_nxt;

   logic                     armed, host_wr, host_rd;
   logic                     ctrl_wr, flush, soft_rst, start_req, wr_req, addr_wr;
   logic                     idle, go_wr, go_rd, ack_cmd, push, pop, err_set;
   logic                     autoinc, err, rd_active, busy;
   logic [15:0]              burst_len, remaining, status;
   logic [SD_DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [LVL_W-1:0]         level;
   logic                     fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0]    rd_mux;

   // One action per chip-select assertion; csn high re-arms.
   assign host_wr   = armed & ~csn & ~wen &  oen;
   assign host_rd   = armed & ~csn &  wen & ~oen;
   assign ctrl_wr   = host_wr & (address == A_CTRL) & (data_out[15:8] == 8'hA5);
   assign flush     = ctrl_wr & data_out[1];
   assign start_req = ctrl_wr & data_out[0];
   assign soft_rst  = sd_rst | (ctrl_wr & data_out[4]);
   assign wr_req    = host_wr & (address == A_WR);
   assign addr_wr   = host_wr & ((address == A_LO) | (address == A_HI));
   assign idle      = (state == IDLE);
   assign fifo_full  = (level == LVL_W'(RD_FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign go_wr     = wr_req & idle & ~soft_rst;
   assign go_rd     = start_req & idle & (burst_len != 16'd0) & ~fifo_full & ~soft_rst;
   assign ack_cmd   = sd_ack & ((state == WR_REQ) | (state == RD_REQ)) & ~soft_rst;
   assign push      = (state == RD_WAIT) & sd_rd_ready & (remaining != 16'd0) & ~flush & ~soft_rst;
   assign pop       = host_rd & (address == A_RD) & ~fifo_empty;
   assign err_set   = (~idle & (wr_req | start_req | addr_wr)) |
                      (host_rd & (address == A_RD) & fifo_empty);
   assign rd_active = (state == RD_REQ) | (state == RD_WAIT) | (state == RD_STALL);
   assign busy      = sd_busy | ~idle;
   assign status    = {8'(level), err, fifo_full, autoinc, sd_rst,
                       ~fifo_empty, busy, (state == WR_REQ), rd_active};

   always_comb begin
      state_nxt    = state;
      sd_wr_enable = 1'b0;
      sd_rd_enable = 1'b0;
      case (state)
         IDLE: begin
            if (go_wr)      state_nxt = WR_REQ;
            else if (go_rd) state_nxt = RD_REQ;
         end
         WR_REQ: begin
            sd_wr_enable = 1'b1;
            if (sd_ack) state_nxt = IDLE;
         end
         RD_REQ: begin
            sd_rd_enable = 1'b1;
            if (sd_ack) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            // remaining==0 here means a flush happened: the word is dropped.
            if (sd_rd_ready)
               state_nxt = ((remaining <= 16'd1) | flush) ? IDLE : RD_STALL;
         end
         RD_STALL: begin
            if ((remaining == 16'd0) | flush) state_nxt = IDLE;
            else if (!fifo_full)              state_nxt = RD_REQ;
         end
         default: state_nxt = IDLE;
      endcase
      if (soft_rst) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         armed      <= 1'b1;
         sd_rst     <= 1'b0;
         autoinc    <= 1'b0;
         err        <= 1'b0;
         burst_len  <= '0;
         remaining  <= '0;
         sd_addr    <= '0;
         sd_wr_data <= '0;
         data_in    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
      end else begin
         state <= state_nxt;
         if (csn)                     armed <= 1'b1;
         else if (host_wr | host_rd)  armed <= 1'b0;
         if (ctrl_wr) begin
            sd_rst  <= data_out[4];
            autoinc <= data_out[5];
         end
         if (host_wr & (address == A_LEN)) burst_len <= data_out[15:0];
         if (go_wr) sd_wr_data <= data_out[SD_DATA_WIDTH-1:0];
         if (addr_wr & idle) begin
            if (address == A_LO) sd_addr[15:0] <= data_out[15:0];
            else                 sd_addr[SD_ADDR_WIDTH-1:16] <= data_out[SD_ADDR_WIDTH-17:0];
         end else if (ack_cmd & autoinc) begin
            sd_addr <= sd_addr + SD_ADDR_WIDTH'(1);
         end
         if (soft_rst | flush) remaining <= '0;
         else if (go_rd)       remaining <= burst_len;
         else if (push)        remaining <= remaining - 16'd1;
         if (soft_rst | flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push & ~pop)      level <= level + LVL_W'(1);
            else if (~push & pop) level <= level - LVL_W'(1);
         end
         if (err_set)                             err <= 1'b1;
         else if (host_rd & (address == A_CTRL))  err <= 1'b0;
         if (host_rd) data_in <= rd_mux;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= sd_rd_data;
   end

`ifdef GPMC_BRIDGE_STATS_EN
   localparam logic [ADDR_WIDTH-1:0] A_WRC = ADDR_WIDTH'(6);
   localparam logic [ADDR_WIDTH-1:0] A_RDC = ADDR_WIDTH'(7);
   logic [15:0] wr_count, rd_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (host_wr & (address == A_WRC))       wr_count <= '0;
         else if (ack_cmd & (state == WR_REQ))   wr_count <= wr_count + 16'd1;
         if (host_wr & (address == A_RDC))       rd_count <= '0;
         else if (push)                          rd_count <= rd_count + 16'd1;
      end
   end
`endif

   always_comb begin
      rd_mux = '0;
      case (address)
         A_CTRL:  rd_mux = DATA_WIDTH'(status);
         A_LO:    rd_mux = DATA_WIDTH'(sd_addr[15:0]);
         A_HI:    rd_mux = DATA_WIDTH'(sd_addr[SD_ADDR_WIDTH-1:16]);
         A_WR:    rd_mux = DATA_WIDTH'(sd_wr_data);
         A_RD:    rd_mux = fifo_empty ? '0 : DATA_WIDTH'(fifo_mem[rd_ptr]);
         A_LEN:   rd_mux = DATA_WIDTH'(burst_len);
`ifdef GPMC_BRIDGE_STATS_EN
         A_WRC:   rd_mux = DATA_WIDTH'(wr_count);
         A_RDC:   rd_mux = DATA_WIDTH'(rd_count);
`endif
         default: rd_mux = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_gpmc_sdram_bridge.sv
`default_nettype none
// ============================================================================
// tb_gpmc_sdram_bridge : directed/randomized bench with an SDRAM responder
// and a queue/array reference of what the SDRAM should hold.
// Revision: 1.0
// ============================================================================
module tb_gpmc_sdram_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, csn, wen, oen, sd_busy;
   logic [3:0]  address;
   logic [15:0] data_out, data_in;
   logic [24:0] sd_addr;
   logic [7:0]  sd_wr_data, sd_rd_data;
   logic        sd_wr_enable, sd_rd_enable, sd_rd_ready, sd_ack, sd_rst;

   gpmc_sdram_bridge dut (
      .clk(clk), .rst_n(rst_n), .csn(csn), .wen(wen), .oen(oen),
      .address(address), .data_out(data_out), .data_in(data_in),
      .sd_addr(sd_addr), .sd_wr_data(sd_wr_data),
      .sd_wr_enable(sd_wr_enable), .sd_rd_enable(sd_rd_enable),
      .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready),
      .sd_busy(sd_busy), .sd_ack(sd_ack), .sd_rst(sd_rst)
   );

   int total = 0;
   int bad   = 0;
   int wr_acks = 0;
   bit [7:0] sdmem   [bit [24:0]];
   bit [7:0] ref_mem [bit [24:0]];
   int unsigned lat = 0, rd_lat = 0;
   bit          rd_pend = 0;
   logic [7:0]  rd_word;

   // Unwritten SDRAM locations hold an address-derived pattern.
   function automatic bit [7:0] fill(input bit [24:0] a);
      return 8'(int'(a) * 37 + 11);
   endfunction
   function automatic bit [7:0] sd_val(input bit [24:0] a);
      return sdmem.exists(a) ? sdmem[a] : fill(a);
   endfunction
   function automatic bit [7:0] ref_val(input bit [24:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   // SDRAM controller responder: random ack latency, read data 1-3 cycles after ack.
   always @(negedge clk) begin
      sd_ack      = 1'b0;
      sd_rd_ready = 1'b0;
      if (!rst_n || sd_rst) begin
         lat = 0; rd_pend = 0; sd_rd_data = '0;
      end else if (rd_pend) begin
         if (rd_lat == 0) begin
            sd_rd_ready = 1'b1; sd_rd_data = rd_word; rd_pend = 0;
         end else rd_lat--;
      end else if (sd_wr_enable || sd_rd_enable) begin
         if (lat == 0) begin
            sd_ack = 1'b1;
            lat = $urandom_range(3, 0);
            if (sd_wr_enable) begin
               sdmem[sd_addr] = sd_wr_data;
               wr_acks++;
            end else begin
               rd_pend = 1; rd_word = sd_val(sd_addr); rd_lat = $urandom_range(2, 0);
            end
         end else lat--;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input int a, input int d);
      @(negedge clk);
      csn = 1'b0; wen = 1'b0; oen = 1'b1; address = 4'(a); data_out = 16'(d);
      repeat (2) @(negedge clk);
      csn = 1'b1; wen = 1'b1; oen = 1'b1;
   endtask

   task automatic host_read(input int a, output logic [15:0] d);
      @(negedge clk);
      csn = 1'b0; wen = 1'b1; oen = 1'b0; address = 4'(a);
      @(negedge clk);
      d = data_in;
      @(negedge clk);
      csn = 1'b1; wen = 1'b1; oen = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input int a, input logic [15:0] exp);
      logic [15:0] v;
      host_read(a, v);
      chk(tag, 64'(v), 64'(exp));
   endtask

   task automatic wait_wr(input int n);
      for (int i = 0; i < 60 && wr_acks < n; i++) @(negedge clk);
      chk("write_ack_count", 64'(wr_acks), 64'(n));
   endtask

   initial begin
      bit [7:0]    b [4];
      bit [7:0]    q [$];
      bit [7:0]    x, y;
      bit [24:0]   ptr;
      logic [15:0] v;

      csn = 1; wen = 1; oen = 1; address = '0; data_out = '0; sd_busy = 0; rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("reset_outputs", {data_in, sd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable, sd_rst}, 64'd0);
      rd_chk("reset_status", 0, 16'h0000);

      // CTRL key qualification
      host_write(0, 16'h1234);
      rd_chk("ctrl_bad_key", 0, 16'h0000);
      host_write(0, 16'hA520);
      rd_chk("ctrl_autoinc", 0, 16'h0020);

      // Auto-incrementing writes
      b[0] = 8'h5A; b[1] = 8'h3C; b[2] = 8'($urandom); b[3] = 8'($urandom);
      host_write(1, 16'h0100);
      host_write(2, 16'h0000);
      ptr = 25'h100;
      for (int i = 0; i < 4; i++) begin
         host_write(3, {8'h00, b[i]});
         wait_wr(i + 1);
         ref_mem[ptr] = b[i];
         ptr++;
      end
      for (int i = 0; i < 4; i++)
         chk("sdram_write_data", 64'(sd_val(25'h100 + 25'(i))), 64'(b[i]));
      rd_chk("addr_lo_after_writes", 1, 16'h0104);
      rd_chk("addr_hi_after_writes", 2, 16'h0000);
      rd_chk("wr_data_readback", 3, {8'h00, b[3]});
`ifdef GPMC_BRIDGE_STATS_EN
      rd_chk("wr_count", 6, 16'd4);
`else
      rd_chk("reg6_absent", 6, 16'd0);
`endif

      // Burst of 10 into an 8-deep FIFO: fills and stalls
      host_write(1, 16'h0100);
      host_write(5, 16'd10);
      for (int i = 0; i < 10; i++) q.push_back(ref_val(25'h100 + 25'(i)));
      host_write(0, 16'hA521);
      repeat (150) @(negedge clk);
      chk("stall_rd_enable", 64'(sd_rd_enable), 64'd0);
      rd_chk("status_full_stall", 0, 16'h086D);
      for (int i = 0; i < 2; i++) rd_chk("burst_pop", 4, {8'h00, q.pop_front()});
      repeat (60) @(negedge clk);
      rd_chk("status_burst_done", 0, 16'h0868);
      for (int i = 0; i < 8; i++) rd_chk("burst_pop", 4, {8'h00, q.pop_front()});
      rd_chk("status_drained", 0, 16'h0020);
      rd_chk("addr_after_burst", 1, 16'h010A);

      // WR_DATA during burst is dropped and flags err
      x = b[3] ^ 8'hFF;
      host_write(5, 16'd6);
      for (int i = 0; i < 6; i++) q.push_back(ref_val(25'h10A + 25'(i)));
      host_write(0, 16'hA521);
      host_write(3, {8'h00, x});
      repeat (100) @(negedge clk);
      rd_chk("status_err_set", 0, 16'h06A8);
      rd_chk("status_err_cleared", 0, 16'h0628);
      rd_chk("dropped_wr_data", 3, {8'h00, b[3]});
      for (int i = 0; i < 6; i++) rd_chk("burst2_pop", 4, {8'h00, q.pop_front()});
      rd_chk("pop_empty_zero", 4, 16'h0000);
      rd_chk("status_pop_empty_err", 0, 16'h00A0);
`ifdef GPMC_BRIDGE_STATS_EN
      rd_chk("rd_count", 7, 16'd16);
`else
      rd_chk("reg7_absent", 7, 16'd0);
`endif

      // Zero-length burst is a no-op
      host_write(5, 16'd0);
      host_write(0, 16'hA521);
      repeat (10) @(negedge clk);
      rd_chk("burst_len_zero", 0, 16'h0020);

      // Address write while busy, then flush mid-burst
      host_write(1, 16'h0200);
      host_write(5, 16'd8);
      host_write(0, 16'hA521);
      host_write(1, 16'h5555);
      host_write(0, 16'hA522);
      repeat (40) @(negedge clk);
      rd_chk("status_after_flush", 0, 16'h00A0);
      rd_chk("status_after_flush2", 0, 16'h0020);

      // Address wrap at the top of the SDRAM space
      y = 8'($urandom);
      host_write(1, 16'hFFFF);
      host_write(2, 16'h01FF);
      rd_chk("addr_hi_max", 2, 16'h01FF);
      host_write(3, {8'h00, y});
      wait_wr(5);
      chk("sdram_top_word", 64'(sd_val(25'h1FFFFFF)), 64'(y));
      rd_chk("addr_lo_wrapped", 1, 16'h0000);
      rd_chk("addr_hi_wrapped", 2, 16'h0000);

      // Soft reset mid-burst
      host_write(5, 16'd8);
      host_write(0, 16'hA521);
      host_write(0, 16'hA510);
      repeat (20) @(negedge clk);
      chk("soft_rst_outputs", {sd_rst, sd_rd_enable, sd_wr_enable}, 64'b100);
      rd_chk("status_soft_rst", 0, 16'h0010);
      host_write(0, 16'hA500);
      rd_chk("status_soft_rst_off", 0, 16'h0000);

      // External busy, counter clear, unmapped register
      sd_busy = 1'b1;
      rd_chk("status_sd_busy", 0, 16'h0004);
      sd_busy = 1'b0;
      host_write(6, 16'h1234);
      rd_chk("wr_count_cleared", 6, 16'h0000);
      rd_chk("unmapped_reg", 8, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
